// File: rtl/starfield_mixer_if.sv
// Pixel-side bundle for starfield_mixer: layer inputs, fade requests and mixed outputs.
// The tint member exists only when STARFIELD_MIXER_TINT_EN is defined.
interface starfield_mixer_if;
  logic       en;
  logic       hblank;
  logic       vblank;
  logic       sf_on;
  logic [7:0] sf_star;
  logic [7:0] fg_r;
  logic [7:0] fg_g;
  logic [7:0] fg_b;
  logic       fg_opaque;
  logic       fade_in_req;
  logic       fade_out_req;
`ifdef STARFIELD_MIXER_TINT_EN
  logic [2:0] tint;
`endif
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       hblank_o;
  logic       vblank_o;
  logic [4:0] fade_level;
  logic       fade_busy;

  modport master (
`ifdef STARFIELD_MIXER_TINT_EN
    output tint,
`endif
    output en, hblank, vblank, sf_on, sf_star, fg_r, fg_g, fg_b, fg_opaque,
    output fade_in_req, fade_out_req,
    input  r, g, b, hblank_o, vblank_o, fade_level, fade_busy
  );

  modport slave (
`ifdef STARFIELD_MIXER_TINT_EN
    input  tint,
`endif
    input  en, hblank, vblank, sf_on, sf_star, fg_r, fg_g, fg_b, fg_opaque,
    input  fade_in_req, fade_out_req,
    output r, g, b, hblank_o, vblank_o, fade_level, fade_busy
  );
endinterface

// File: rtl/starfield_mixer.sv
// Two-stage starfield/foreground mixer with a frame-paced fade FSM on the star gain.
// Define STARFIELD_MIXER_TINT_EN to add a per-channel star tint input.
module starfield_mixer #(
  parameter int unsigned FADE_DIV = 2,
  parameter bit          START_ON = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  starfield_mixer_if.slave    pix_if
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_ON       = 2'd2,
    ST_FADE_OUT = 2'd3
  } fade_state_e;

  localparam logic [4:0]  LEVEL_MAX   = 5'd16;
  localparam logic [3:0]  DIV_LAST    = 4'(FADE_DIV - 1);
  localparam fade_state_e RESET_STATE = START_ON ? ST_ON : ST_OFF;
  localparam logic [4:0]  RESET_LEVEL = START_ON ? LEVEL_MAX : 5'd0;

  fade_state_e state_q, state_d;
  logic [4:0]  level_q, level_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic        vblank_prev_q;
  logic        frame_tick;
  logic        fade_step;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    frame_tick  = pix_if.vblank & ~vblank_prev_q;
    fade_step   = 1'b0;

    if ((state_q == ST_FADE_IN || state_q == ST_FADE_OUT) && frame_tick) begin
      if (frame_cnt_q >= DIV_LAST) begin
        frame_cnt_d = 4'd0;
        fade_step   = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 4'd1;
      end
    end

    case (state_q)
      ST_FADE_IN: begin
        if (fade_step) begin
          if (level_q < LEVEL_MAX) level_d = level_q + 5'd1;
          if (level_q >= LEVEL_MAX - 5'd1) state_d = ST_ON;
        end
      end
      ST_FADE_OUT: begin
        if (fade_step) begin
          if (level_q != 5'd0) level_d = level_q - 5'd1;
          if (level_q <= 5'd1) state_d = ST_OFF;
        end
      end
      default: ;
    endcase

    // A fade-out request masks a simultaneous fade-in; a direction change keeps the level.
    if (pix_if.fade_out_req) begin
      if (state_q == ST_ON || state_q == ST_FADE_IN) begin
        state_d     = ST_FADE_OUT;
        level_d     = level_q;
        frame_cnt_d = 4'd0;
      end
    end else if (pix_if.fade_in_req) begin
      if (state_q == ST_OFF || state_q == ST_FADE_OUT) begin
        state_d     = ST_FADE_IN;
        level_d     = level_q;
        frame_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RESET_STATE;
      level_q       <= RESET_LEVEL;
      frame_cnt_q   <= 4'd0;
      vblank_prev_q <= 1'b1;
    end else if (pix_if.en) begin
      state_q       <= state_d;
      level_q       <= level_d;
      frame_cnt_q   <= frame_cnt_d;
      vblank_prev_q <= pix_if.vblank;
    end
  end

  logic [12:0] star_prod;
  logic [8:0]  star_scaled;
  logic [7:0]  star_int;

  assign star_prod   = {5'd0, pix_if.sf_star} * {8'd0, level_q};
  assign star_scaled = 9'(star_prod >> 4);
  assign star_int    = star_scaled[8] ? 8'hFF : star_scaled[7:0];

  logic [7:0] s1_star_q;
  logic       s1_sf_on_q;
  logic       s1_hblank_q;
  logic       s1_vblank_q;
  logic [7:0] s1_fg_r_q, s1_fg_g_q, s1_fg_b_q;
  logic       s1_opaque_q;
  logic [2:0] star_mask;
`ifdef STARFIELD_MIXER_TINT_EN
  logic [2:0] s1_tint_q;
  assign star_mask = s1_tint_q;
`else
  assign star_mask = 3'b111;
`endif

  logic [7:0] r_q, g_q, b_q;
  logic [7:0] r_d, g_d, b_d;
  logic       hblank_o_q, vblank_o_q;

  // Blanking dominates, then an opaque foreground, then the faded star.
  always_comb begin
    r_d = 8'd0;
    g_d = 8'd0;
    b_d = 8'd0;
    if (!(s1_hblank_q || s1_vblank_q)) begin
      if (s1_opaque_q) begin
        r_d = s1_fg_r_q;
        g_d = s1_fg_g_q;
        b_d = s1_fg_b_q;
      end else if (s1_sf_on_q) begin
        r_d = star_mask[2] ? s1_star_q : 8'd0;
        g_d = star_mask[1] ? s1_star_q : 8'd0;
        b_d = star_mask[0] ? s1_star_q : 8'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_star_q   <= 8'd0;
      s1_sf_on_q  <= 1'b0;
      s1_hblank_q <= 1'b1;
      s1_vblank_q <= 1'b1;
      s1_fg_r_q   <= 8'd0;
      s1_fg_g_q   <= 8'd0;
      s1_fg_b_q   <= 8'd0;
      s1_opaque_q <= 1'b0;
`ifdef STARFIELD_MIXER_TINT_EN
      s1_tint_q   <= 3'd0;
`endif
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      b_q         <= 8'd0;
      hblank_o_q  <= 1'b1;
      vblank_o_q  <= 1'b1;
    end else if (pix_if.en) begin
      s1_star_q   <= star_int;
      s1_sf_on_q  <= pix_if.sf_on;
      s1_hblank_q <= pix_if.hblank;
      s1_vblank_q <= pix_if.vblank;
      s1_fg_r_q   <= pix_if.fg_r;
      s1_fg_g_q   <= pix_if.fg_g;
      s1_fg_b_q   <= pix_if.fg_b;
      s1_opaque_q <= pix_if.fg_opaque;
`ifdef STARFIELD_MIXER_TINT_EN
      s1_tint_q   <= pix_if.tint;
`endif
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      hblank_o_q  <= s1_hblank_q;
      vblank_o_q  <= s1_vblank_q;
    end
  end

  assign pix_if.r          = r_q;
  assign pix_if.g          = g_q;
  assign pix_if.b          = b_q;
  assign pix_if.hblank_o   = hblank_o_q;
  assign pix_if.vblank_o   = vblank_o_q;
  assign pix_if.fade_level = level_q;
  assign pix_if.fade_busy  = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT);

endmodule

// File: doc/starfield_mixer.md
STARFIELD_MIXER -- requirements
Module: starfield_mixer

Interface
REQ-001 Parameter FADE_DIV, default 2, meaning number of frames per fade-level step (legal range 1..15).
REQ-002 Parameter START_ON, default 0, meaning that 1 resets the fade FSM into ON at level 16 instead of OFF at level 0.
REQ-003 clk  in  1  pixel-domain clock; reset is asynchronous and active-high, port name rst.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 en  in  1  pixel enable; pipeline and FSM advance only on cycles with en=1.
REQ-006 hblank, vblank  in  1 each  video blanking, aligned with sf_on/sf_star.
REQ-007 sf_on  in  1  star present at this pixel.
REQ-008 sf_star  in  8  star brightness.
REQ-009 fg_r, fg_g, fg_b  in  8 each  foreground layer colour.
REQ-010 fg_opaque  in  1  foreground pixel covers the starfield.
REQ-011 fade_in_req, fade_out_req  in  1 each  single-cycle fade requests, sampled when en=1.
REQ-012 r, g, b  out  8 each  mixed pixel colour.
REQ-013 hblank_o, vblank_o  out  1 each  blanking delayed to match r/g/b.
REQ-014 fade_level  out  5  current starfield gain, range 0..16.
REQ-015 fade_busy  out  1  high in FADE_IN or FADE_OUT.

Function
REQ-016 Pipeline latency SHALL be exactly 2 en-qualified cycles from inputs to r/g/b/hblank_o/vblank_o, with all inputs delayed equally.
REQ-017 Stage 1 SHALL compute star intensity = (sf_star * fade_level) >> 4, using a 13-bit product and saturating to 255.
REQ-018 Stage 2 SHALL select the output as follows: if blanking, r=g=b=0; else if fg_opaque, fg_r/g/b; else if sf_on, star intensity on the enabled channels; else 0.
REQ-019 FSM states SHALL be OFF (level 0), FADE_IN, ON (level 16) and FADE_OUT.
REQ-020 A frame tick SHALL be the en-qualified rising edge of vblank; a 4-bit frame counter counts ticks while in FADE_IN/FADE_OUT and wraps at FADE_DIV, emitting a step.
REQ-021 On a step, FADE_IN SHALL increment the level and go to ON when the level reaches 16; FADE_OUT SHALL decrement the level and go to OFF when the level reaches 0.
REQ-022 fade_in_req SHALL move OFF or FADE_OUT to FADE_IN and fade_out_req SHALL move ON or FADE_IN to FADE_OUT; the level is kept and the frame counter is cleared on either transition.
REQ-023 A request that matches the current state or direction SHALL be ignored.
REQ-024 When both requests are asserted in the same cycle, fade_out_req SHALL win.
REQ-025 The level SHALL never wrap below 0 or above 16.
REQ-026 A level change SHALL take effect on the next en cycle, including mid-line.
REQ-027 With en=0, all registers SHALL hold their values and requests SHALL be ignored.

Reset
REQ-028 Asynchronous reset SHALL clear r/g/b to 0, set hblank_o and vblank_o to 1, clear the pipeline and frame counter, and set fade_busy to 0.
REQ-029 On reset, state and fade_level SHALL be OFF/0, or ON/16 when START_ON=1.
REQ-030 Reset asserted mid-fade SHALL abort the fade immediately.
REQ-031 The previous-vblank register SHALL reset to 1 so that no spurious tick occurs on the first frame.

Configuration
REQ-032 Macro STARFIELD_MIXER_TINT_EN SHALL control the star tint feature.
REQ-033 When STARFIELD_MIXER_TINT_EN is defined, a tint input (3 bits, [2]=R, [1]=G, [0]=B) SHALL be added, registered in stage 1, and each channel with its tint bit 0 SHALL output 0 for star pixels.
REQ-034 When STARFIELD_MIXER_TINT_EN is undefined, the tint port SHALL be absent and star pixels SHALL be grey on all three channels.
REQ-035 Foreground and blanking behaviour SHALL be identical with and without STARFIELD_MIXER_TINT_EN.

Verification
REQ-036 START_ON=1, en=1, sf_on=1, sf_star=8'hC8, no blanking, fg_opaque=0 -> r=g=b=8'hC8 two cycles later.
REQ-037 Same stimulus with fg_opaque=1 and fg=(12,34,56) -> r,g,b=(12,34,56); hblank=1 -> 0,0,0 with hblank_o=1 after 2 cycles.
REQ-038 START_ON=0, FADE_DIV=2, pulse fade_in_req, then 32 vblank edges -> level steps 0->16 every 2 frames, fade_busy falls at level 16, sf_star=255 yields 255.
REQ-039 At level 9 during FADE_IN, pulse fade_out_req -> FADE_OUT starting from 9 and reaching 0/OFF after 18 frames; fade_in_req and fade_out_req in the same cycle -> FADE_OUT.
REQ-040 Assert rst asynchronously mid-fade at level 5 -> fade_level=0, fade_busy=0, r/g/b=0 immediately, without waiting for a clk edge.
REQ-041 TINT_EN defined, tint=3'b100, star 8'h80 at level 16 -> r=8'h80, g=0, b=0.
